mem_wb_pipe: RTL and testbench

Pipeline register stage that sits directly upstream of the writeback (WB) stage and feeds it completed memory-stage results. It is a 2-entry skid buffer with a valid/ready handshake on both sides, a synchronous flush, and a saturating back-pressure (stall) counter. Its in_ready is a pure function of registered state, which breaks the combinational ready path from WB back into the memory stage.

---
 rtl/mem_wb_pipe.sv | 142 ++++++++++++++
 tb/tb_mem_wb_pipe.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_pipe.sv
// Two-entry skid buffer between the memory stage and writeback.
// in_ready is decoded from registered state only, cutting the WB ready path.
module mem_wb_pipe #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned RD_W    = 5,
   parameter int unsigned STALL_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_we,
   input  logic [RD_W-1:0]    in_rd,
   input  logic [DATA_W-1:0]  in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_we,
   output logic [RD_W-1:0]    out_rd,
   output logic [DATA_W-1:0]  out_data,
   output logic [1:0]         occupancy,
   output logic [STALL_W-1:0] stall_cnt
);

   typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

   state_e state_q, state_d;

   // Entry 0 is always the head; entry 1 only holds data while FULL.
   logic              e0_we_q, e1_we_q;
   logic [RD_W-1:0]   e0_rd_q, e1_rd_q;
   logic [DATA_W-1:0] e0_data_q, e1_data_q;

   logic [STALL_W-1:0] stall_q, stall_d;

   logic push, pop;
   logic load_e0, load_e1, shift_e1;

   assign in_ready  = (state_q != StFull);
   assign out_valid = (state_q != StEmpty);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   assign out_we    = e0_we_q;
   assign out_rd    = e0_rd_q;
   assign out_data  = e0_data_q;
   assign stall_cnt = stall_q;

   always_comb begin
      unique case (state_q)
         StEmpty: occupancy = 2'd0;
         StOne:   occupancy = 2'd1;
         StFull:  occupancy = 2'd2;
         default: occupancy = 2'd0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      load_e0  = 1'b0;
      load_e1  = 1'b0;
      shift_e1 = 1'b0;
      unique case (state_q)
         StEmpty: begin
            if (push) begin
               load_e0 = 1'b1;
               state_d = StOne;
            end
         end
         StOne: begin
            if (push && pop) begin
               load_e0 = 1'b1;
            end else if (push) begin
               load_e1 = 1'b1;
               state_d = StFull;
            end else if (pop) begin
               state_d = StEmpty;
            end
         end
         StFull: begin
            if (pop) begin
               shift_e1 = 1'b1;
               state_d  = StOne;
            end
         end
         default: state_d = StEmpty;
      endcase
      // A push in the flush cycle is dropped; a pop has already been taken by WB.
      if (flush) begin
         state_d  = StEmpty;
         load_e0  = 1'b0;
         load_e1  = 1'b0;
         shift_e1 = 1'b0;
      end
   end

   always_comb begin
      stall_d = stall_q;
      if (out_valid && !out_ready && (stall_q != {STALL_W{1'b1}})) begin
         stall_d = stall_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StEmpty;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         stall_q <= stall_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e0_we_q   <= 1'b0;
         e0_rd_q   <= '0;
         e0_data_q <= '0;
      end else if (load_e0) begin
         e0_we_q   <= in_we;
         e0_rd_q   <= in_rd;
         e0_data_q <= in_data;
      end else if (shift_e1) begin
         e0_we_q   <= e1_we_q;
         e0_rd_q   <= e1_rd_q;
         e0_data_q <= e1_data_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e1_we_q   <= 1'b0;
         e1_rd_q   <= '0;
         e1_data_q <= '0;
      end else if (load_e1) begin
         e1_we_q   <= in_we;
         e1_rd_q   <= in_rd;
         e1_data_q <= in_data;
      end
   end

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed bench for mem_wb_pipe; a second instance with a 4-bit stall counter
// shares the stimulus and is checked for saturation.
module tb_mem_wb_pipe;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic        in_we;
   logic [4:0]  in_rd;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic        out_we;
   logic [4:0]  out_rd;
   logic [31:0] out_data;
   logic [1:0]  occupancy;
   logic [15:0] stall_cnt;

   logic        s_in_ready, s_out_valid, s_out_we;
   logic [4:0]  s_out_rd;
   logic [31:0] s_out_data;
   logic [1:0]  s_occupancy;
   logic [3:0]  s_stall_cnt;

   int checks = 0;
   int errors = 0;
   int exp_stall = 0;

   mem_wb_pipe dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_we(in_we), .in_rd(in_rd),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_we(out_we), .out_rd(out_rd), .out_data(out_data),
      .occupancy(occupancy), .stall_cnt(stall_cnt)
   );

   mem_wb_pipe #(.STALL_W(4)) dut_sat (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(s_in_ready), .in_we(in_we), .in_rd(in_rd),
      .in_data(in_data), .out_valid(s_out_valid), .out_ready(out_ready),
      .out_we(s_out_we), .out_rd(s_out_rd), .out_data(s_out_data),
      .occupancy(s_occupancy), .stall_cnt(s_stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_occ"}, 32'(occupancy), 32'd0);
   endtask

   task automatic drive(input logic v, input logic [4:0] rd, input logic [31:0] d);
      in_valid = v;
      in_rd    = rd;
      in_data  = d;
      in_we    = rd[0];
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
      drive(1'b0, 5'd0, 32'd0);

      // Reset and idle
      repeat (3) tick();
      chk_idle("rst");
      chk("rst_stall", 32'(stall_cnt), 32'd0);
      chk("rst_data", out_data, 32'd0);
      chk("rst_rd", 32'(out_rd), 32'd0);
      chk("rst_we", 32'(out_we), 32'd0);
      rst_n = 1'b1;
      repeat (2) begin
         tick();
         chk_idle("idle");
         chk("idle_stall", 32'(stall_cnt), 32'd0);
      end

      // Streaming at full rate: occupancy stays at one
      out_ready = 1'b1;
      for (int rd = 1; rd <= 8; rd++) begin
         drive(1'b1, 5'(rd), 32'h100 + 32'(rd));
         tick();
         chk("stream_valid", 32'(out_valid), 32'd1);
         chk("stream_rd", 32'(out_rd), 32'(rd));
         chk("stream_data", out_data, 32'h100 + 32'(rd));
         chk("stream_we", 32'(out_we), 32'(rd & 1));
         chk("stream_occ", 32'(occupancy), 32'd1);
      end
      drive(1'b0, 5'd0, 32'd0);
      tick();
      chk_idle("stream_drain");
      chk("stream_stall", 32'(stall_cnt), 32'd0);

      // Back-pressure fill to FULL, then hold a third push
      out_ready = 1'b0;
      drive(1'b1, 5'd3, 32'hA);
      tick();
      chk("bp_occ1", 32'(occupancy), 32'd1);
      chk("bp_stall0", 32'(stall_cnt), 32'(exp_stall));
      drive(1'b1, 5'd4, 32'hB);
      tick();
      exp_stall += 1;
      chk("bp_occ2", 32'(occupancy), 32'd2);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      drive(1'b1, 5'd5, 32'hC);
      for (int i = 0; i < 5; i++) begin
         tick();
         exp_stall += 1;
         chk("bp_hold_data", out_data, 32'hA);
         chk("bp_hold_rd", 32'(out_rd), 32'd3);
         chk("bp_hold_ready", 32'(in_ready), 32'd0);
      end
      chk("bp_stall", 32'(stall_cnt), 32'(exp_stall));
      out_ready = 1'b1;
      tick();
      chk("bp_out_b", out_data, 32'hB);
      chk("bp_occ_b", 32'(occupancy), 32'd1);
      tick();
      chk("bp_out_c", out_data, 32'hC);
      chk("bp_rd_c", 32'(out_rd), 32'd5);
      drive(1'b0, 5'd0, 32'd0);
      tick();
      chk_idle("bp_drain");
      chk("bp_stall_end", 32'(stall_cnt), 32'(exp_stall));

      // Push with pop in ONE: new entry becomes head
      out_ready = 1'b0;
      drive(1'b1, 5'd7, 32'h77);
      tick();
      chk("pp_rd7", 32'(out_rd), 32'd7);
      out_ready = 1'b1;
      drive(1'b1, 5'd9, 32'h99);
      tick();
      chk("pp_rd9", 32'(out_rd), 32'd9);
      chk("pp_occ", 32'(occupancy), 32'd1);
      drive(1'b0, 5'd0, 32'd0);
      tick();
      chk_idle("pp_drain");

      // Flush from FULL with a concurrent push that must be dropped
      out_ready = 1'b0;
      drive(1'b1, 5'd2, 32'h22);
      tick();
      drive(1'b1, 5'd6, 32'h66);
      tick();
      exp_stall += 1;
      chk("fl_occ2", 32'(occupancy), 32'd2);
      chk("fl_rd2", 32'(out_rd), 32'd2);
      out_ready = 1'b1;
      flush = 1'b1;
      drive(1'b1, 5'd8, 32'h88);
      tick();
      flush = 1'b0;
      drive(1'b0, 5'd0, 32'd0);
      chk_idle("fl_after");
      chk("fl_stall", 32'(stall_cnt), 32'(exp_stall));
      repeat (2) begin
         tick();
         chk("fl_no_rd8", 32'(out_valid), 32'd0);
      end

      // Saturation of the 4-bit counter, then async reset between edges
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      chk("sat_rst", 32'(s_stall_cnt), 32'd0);
      out_ready = 1'b0;
      drive(1'b1, 5'd1, 32'h11);
      tick();
      drive(1'b0, 5'd0, 32'd0);
      repeat (20) tick();
      chk("sat_4bit", 32'(s_stall_cnt), 32'd15);
      chk("sat_16bit", 32'(stall_cnt), 32'd20);
      chk("sat_valid", 32'(s_out_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_idle("arst");
      chk("arst_stall", 32'(stall_cnt), 32'd0);
      chk("arst_stall4", 32'(s_stall_cnt), 32'd0);
      chk("arst_data", out_data, 32'd0);
      chk("arst_rd", 32'(out_rd), 32'd0);
      chk("arst_we", 32'(s_out_we), 32'd0);
      chk("arst_sat_occ", 32'(s_occupancy), 32'd0);
      #3;
      rst_n = 1'b1;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
